gb_memory_bus: RTL and testbench

//  Game Boy system bus fabric between the CPU and its memories/peripherals (bootrom, cart, VRAM,

---
 rtl/gb_memory_bus_if.sv | 22 ++
 rtl/gb_memory_bus.sv | 113 +++++++++++
 tb/tb_gb_memory_bus.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_memory_bus_if.sv
// CPU-side bus bundle: address, write data and strobe out of the CPU,
// combinational read data back into it. The master modport is the CPU side.
interface gb_memory_bus_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_w;
  logic        cpu_do_write;
  logic [7:0]  cpu_data_r;

  modport master (
    output cpu_addr,
    output cpu_data_w,
    output cpu_do_write,
    input  cpu_data_r
  );

  modport slave (
    input  cpu_addr,
    input  cpu_data_w,
    input  cpu_do_write,
    output cpu_data_r
  );
endinterface

// File: rtl/gb_memory_bus.sv
// Game Boy bus fabric: address decode, read mux, gated write enables,
// boot-ROM overlay flag, IE register and power-on reset stretcher.
// Ports: clk/reset (sync, active-high), cpu (CPU bus interface),
//   *_data_r region read data in, vram_addr, *_we region write enables,
//   sys_reset, bootrom_enabled, interrupt_enable out.
module gb_memory_bus #(
  parameter logic [15:0] BOOTROM_SIZE      = 16'h0100,
  parameter logic [7:0]  RESET_HOLD        = 8'hFF,
  parameter logic [15:0] BOOT_DISABLE_ADDR = 16'hFF50
) (
  input  logic                  clk,
  input  logic                  reset,
  gb_memory_bus_if.slave        cpu,
  input  logic [7:0]            bootrom_data_r,
  input  logic [7:0]            cart_data_r,
  input  logic [7:0]            vram_data_r,
  input  logic [7:0]            wram_data_r,
  input  logic [7:0]            oam_data_r,
  input  logic [7:0]            io_data_r,
  input  logic [7:0]            hram_data_r,
  output logic [15:0]           vram_addr,
  output logic                  cart_we,
  output logic                  vram_we,
  output logic                  wram_we,
  output logic                  oam_we,
  output logic                  io_we,
  output logic                  hram_we,
  output logic                  sys_reset,
  output logic                  bootrom_enabled,
  output logic [4:0]            interrupt_enable
);

  logic [15:0] a;
  logic [7:0]  cnt;
  logic        lo_hit;
  logic        boot_hit;
  logic        rom_hit;
  logic        xram_hit;
  logic        vram_hit;
  logic        wram_hit;
  logic        oam_hit;
  logic        io_hit;
  logic        hram_hit;
  logic        ie_hit;
  logic        wr;

  assign a         = cpu.cpu_addr;
  assign vram_addr = a;

  assign lo_hit   = ~a[15];
  assign boot_hit = lo_hit && (a < BOOTROM_SIZE) && bootrom_enabled;
  assign rom_hit  = lo_hit && !boot_hit;
  assign vram_hit = (a[15:13] == 3'b100);
  assign xram_hit = (a[15:13] == 3'b101);
  assign wram_hit = (a >= 16'hC000) && (a <= 16'hFDFF);
  assign oam_hit  = (a >= 16'hFE00) && (a <= 16'hFE9F);
  assign io_hit   = (a[15:7] == 9'h1FE);
  assign hram_hit = (a >= 16'hFF80) && (a <= 16'hFFFE);
  assign ie_hit   = (a == 16'hFFFF);

  // Bus writes are ignored entirely while peripherals are held in reset.
  assign wr = cpu.cpu_do_write && !sys_reset;

  // MBC registers live under the whole ROM window, boot overlay included.
  assign cart_we = wr && (lo_hit || xram_hit);
  assign vram_we = wr && vram_hit;
  assign wram_we = wr && wram_hit;
  assign oam_we  = wr && oam_hit;
  assign io_we   = wr && io_hit;
  assign hram_we = wr && hram_hit;

  always_comb begin
    cpu.cpu_data_r = 8'hFF;
    unique case (1'b1)
      boot_hit: cpu.cpu_data_r = bootrom_data_r;
      rom_hit:  cpu.cpu_data_r = cart_data_r;
      xram_hit: cpu.cpu_data_r = cart_data_r;
      vram_hit: cpu.cpu_data_r = vram_data_r;
      wram_hit: cpu.cpu_data_r = wram_data_r;
      oam_hit:  cpu.cpu_data_r = oam_data_r;
      io_hit:   cpu.cpu_data_r = io_data_r;
      hram_hit: cpu.cpu_data_r = hram_data_r;
      ie_hit:   cpu.cpu_data_r = {3'b000, interrupt_enable};
      default:  cpu.cpu_data_r = 8'hFF;
    endcase
  end

  // Counter parks at RESET_HOLD once the stretch has elapsed.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 8'd0;
      sys_reset <= 1'b1;
    end else if (cnt == RESET_HOLD) begin
      sys_reset <= 1'b0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_reset) begin
      bootrom_enabled  <= 1'b1;
      interrupt_enable <= 5'd0;
    end else if (cpu.cpu_do_write) begin
      if (ie_hit)
        interrupt_enable <= cpu.cpu_data_w[4:0];
      // One-way latch: only a reset brings the overlay back.
      if (a == BOOT_DISABLE_ADDR && cpu.cpu_data_w != 8'd0)
        bootrom_enabled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gb_memory_bus.sv
// Self-checking bench for gb_memory_bus: vector table, hand sequences
// for reset stretch / overlay / IE, and randomized traffic vs a model.
module tb_gb_memory_bus;

  logic        clk;
  logic        reset;
  logic [7:0]  src_boot, src_cart, src_vram, src_wram;
  logic [7:0]  src_oam, src_io, src_hram;
  logic [15:0] vram_addr;
  logic        cart_we, vram_we, wram_we, oam_we, io_we, hram_we;
  logic        sys_reset, bootrom_enabled;
  logic [4:0]  interrupt_enable;

  gb_memory_bus_if bus ();

  gb_memory_bus dut (
    .clk              (clk),
    .reset            (reset),
    .cpu              (bus.slave),
    .bootrom_data_r   (src_boot),
    .cart_data_r      (src_cart),
    .vram_data_r      (src_vram),
    .wram_data_r      (src_wram),
    .oam_data_r       (src_oam),
    .io_data_r        (src_io),
    .hram_data_r      (src_hram),
    .vram_addr        (vram_addr),
    .cart_we          (cart_we),
    .vram_we          (vram_we),
    .wram_we          (wram_we),
    .oam_we           (oam_we),
    .io_we            (io_we),
    .hram_we          (hram_we),
    .sys_reset        (sys_reset),
    .bootrom_enabled  (bootrom_enabled),
    .interrupt_enable (interrupt_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cycles since reset released, overlay flag, IE.
  int       since = 0;
  logic     m_boot = 1'b1;
  logic [4:0] m_ie = 5'd0;

  function automatic logic m_sysr();
    return since < 256;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [15:0] ad);
    if (ad < 16'h8000)
      return (m_boot && ad < 16'h0100) ? src_boot : src_cart;
    if (ad < 16'hA000) return src_vram;
    if (ad < 16'hC000) return src_cart;
    if (ad < 16'hFE00) return src_wram;
    if (ad < 16'hFEA0) return src_oam;
    if (ad < 16'hFF00) return 8'hFF;
    if (ad < 16'hFF80) return src_io;
    if (ad < 16'hFFFF) return src_hram;
    return {3'b000, m_ie};
  endfunction

  // Bit order {cart, vram, wram, oam, io, hram}.
  function automatic logic [5:0] exp_we(input logic [15:0] ad,
                                        input logic dw);
    if (!dw || m_sysr()) return 6'b0;
    if (ad < 16'h8000) return 6'b100000;
    if (ad < 16'hA000) return 6'b010000;
    if (ad < 16'hC000) return 6'b100000;
    if (ad < 16'hFE00) return 6'b001000;
    if (ad < 16'hFEA0) return 6'b000100;
    if (ad < 16'hFF00) return 6'b000000;
    if (ad < 16'hFF80) return 6'b000010;
    if (ad < 16'hFFFF) return 6'b000001;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] got_we();
    return {cart_we, vram_we, wram_we, oam_we, io_we, hram_we};
  endfunction

  task automatic model_update();
    logic held;
    held = m_sysr();
    if (held) begin
      m_boot = 1'b1;
      m_ie   = 5'd0;
    end else if (bus.cpu_do_write) begin
      if (bus.cpu_addr == 16'hFFFF) m_ie = bus.cpu_data_w[4:0];
      if (bus.cpu_addr == 16'hFF50 && bus.cpu_data_w != 8'd0)
        m_boot = 1'b0;
    end
    if (reset) since = 0;
    else if (since < 1000) since = since + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rd"}, {8'd0, bus.cpu_data_r},
        {8'd0, exp_rd(bus.cpu_addr)});
    chk({tag, "_we"}, {10'd0, got_we()},
        {10'd0, exp_we(bus.cpu_addr, bus.cpu_do_write)});
    chk({tag, "_sysr"}, {15'd0, sys_reset}, {15'd0, m_sysr()});
    chk({tag, "_boot"}, {15'd0, bootrom_enabled}, {15'd0, m_boot});
    chk({tag, "_ie"}, {11'd0, interrupt_enable}, {11'd0, m_ie});
    chk({tag, "_vaddr"}, vram_addr, bus.cpu_addr);
  endtask

  task automatic wait_release(input string nm, input int exp_len);
    int n;
    n = 0;
    while (sys_reset && n < 400) begin
      if (n == 5) begin
        bus.cpu_addr = 16'hFFFF; bus.cpu_data_w = 8'hFF;
        bus.cpu_do_write = 1'b1;
        #1;
        chk({nm, "_we_held_ie"}, {10'd0, got_we()}, 16'd0);
      end
      if (n == 6) begin
        bus.cpu_addr = 16'hFF50; bus.cpu_data_w = 8'h01;
        bus.cpu_do_write = 1'b1;
        #1;
        chk({nm, "_we_held_ff50"}, {10'd0, got_we()}, 16'd0);
      end
      tick();
      n++;
      bus.cpu_do_write = 1'b0;
    end
    chk({nm, "_len"}, 16'(n), 16'(exp_len));
    chk({nm, "_ie0"}, {11'd0, interrupt_enable}, 16'd0);
    chk({nm, "_boot1"}, {15'd0, bootrom_enabled}, 16'd1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  rd;
    logic [5:0]  we;
  } vec_t;

  vec_t tbl[11];
  logic [15:0] picks[22];

  initial begin
    tbl[0]  = '{16'h0050, 8'hA5, 6'b100000};
    tbl[1]  = '{16'h0100, 8'h3C, 6'b100000};
    tbl[2]  = '{16'h8000, 8'h11, 6'b010000};
    tbl[3]  = '{16'hA000, 8'h3C, 6'b100000};
    tbl[4]  = '{16'hC000, 8'h22, 6'b001000};
    tbl[5]  = '{16'hE123, 8'h22, 6'b001000};
    tbl[6]  = '{16'hFE00, 8'h33, 6'b000100};
    tbl[7]  = '{16'hFEA0, 8'hFF, 6'b000000};
    tbl[8]  = '{16'hFF10, 8'h44, 6'b000010};
    tbl[9]  = '{16'hFF80, 8'h55, 6'b000001};
    tbl[10] = '{16'hFFFF, 8'h00, 6'b000000};

    picks = '{16'h0000, 16'h0050, 16'h00FF, 16'h0100, 16'h7FFF,
              16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000,
              16'hE123, 16'hFDFF, 16'hFE00, 16'hFE9F, 16'hFEA0,
              16'hFEFF, 16'hFF00, 16'hFF50, 16'hFF7F, 16'hFF80,
              16'hFFFE, 16'hFFFF};

    src_boot = 8'hA5; src_cart = 8'h3C; src_vram = 8'h11;
    src_wram = 8'h22; src_oam = 8'h33; src_io = 8'h44;
    src_hram = 8'h55;
    bus.cpu_addr = 16'h0; bus.cpu_data_w = 8'h0;
    bus.cpu_do_write = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_sysr", {15'd0, sys_reset}, 16'd1);
    chk("rst_boot", {15'd0, bootrom_enabled}, 16'd1);
    chk("rst_ie", {11'd0, interrupt_enable}, 16'd0);

    reset = 1'b0;
    repeat (99) tick();
    chk("hold_at_100", {15'd0, sys_reset}, 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_release("restart", 256);

    foreach (tbl[i]) begin
      bus.cpu_addr = tbl[i].addr;
      bus.cpu_data_w = 8'h00;
      bus.cpu_do_write = 1'b0;
      #1;
      chk($sformatf("tbl%0d_rd", i), {8'd0, bus.cpu_data_r},
          {8'd0, tbl[i].rd});
      chk($sformatf("tbl%0d_nowe", i), {10'd0, got_we()}, 16'd0);
      bus.cpu_do_write = 1'b1;
      #1;
      chk($sformatf("tbl%0d_we", i), {10'd0, got_we()},
          {10'd0, tbl[i].we});
      bus.cpu_do_write = 1'b0;
      tick();
    end

    bus.cpu_addr = 16'hFF50; bus.cpu_data_w = 8'h01;
    bus.cpu_do_write = 1'b1;
    #1;
    chk("ff50_io_we", {10'd0, got_we()}, 16'b000010);
    tick();
    bus.cpu_do_write = 1'b0;
    bus.cpu_addr = 16'h0050;
    #1;
    chk("ff50_boot_off", {15'd0, bootrom_enabled}, 16'd0);
    chk("ff50_rd_cart", {8'd0, bus.cpu_data_r}, 16'h003C);
    bus.cpu_addr = 16'hFF50; bus.cpu_data_w = 8'h00;
    bus.cpu_do_write = 1'b1;
    tick();
    bus.cpu_do_write = 1'b0;
    bus.cpu_addr = 16'h0050;
    #1;
    chk("ff50_zero_sticky", {15'd0, bootrom_enabled}, 16'd0);
    chk("ff50_zero_rd", {8'd0, bus.cpu_data_r}, 16'h003C);

    bus.cpu_addr = 16'hFFFF; bus.cpu_data_w = 8'hFF;
    bus.cpu_do_write = 1'b1;
    tick();
    bus.cpu_do_write = 1'b0;
    #1;
    chk("ie_rd", {8'd0, bus.cpu_data_r}, 16'h001F);
    chk("ie_reg", {11'd0, interrupt_enable}, 16'h001F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_release("ie_reset", 256);

    for (int i = 0; i < 2000; i++) begin
      int k;
      reset = ($urandom_range(0, 599) == 0);
      src_boot = 8'($urandom); src_cart = 8'($urandom);
      src_vram = 8'($urandom); src_wram = 8'($urandom);
      src_oam  = 8'($urandom); src_io   = 8'($urandom);
      src_hram = 8'($urandom);
      k = $urandom_range(0, 31);
      bus.cpu_addr = (k < 22) ? picks[k] : 16'($urandom);
      bus.cpu_data_w = ($urandom_range(0, 3) == 0) ? 8'h00
                                                   : 8'($urandom);
      bus.cpu_do_write = ($urandom_range(0, 2) == 0);
      #1;
      check_all($sformatf("rnd%0d", i));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
